// File: rtl/ddr4_seq_pkg.sv
// rtl/ddr4_seq_pkg.sv - shared state encoding and LED bit map for the DDR4 reset sequencer
package ddr4_seq_pkg;

    typedef enum logic [2:0] {
        ST_REQ   = 3'd0,
        ST_WAITD = 3'd1,
        ST_WAITC = 3'd2,
        ST_HOLD  = 3'd3,
        ST_RUN   = 3'd4,
        ST_FAIL  = 3'd5
    } seq_state_e;

    localparam int LED_CAL_OK    = 0;
    localparam int LED_FAIL_SEEN = 1;
    localparam int LED_SOC_UP    = 2;
    localparam int LED_AUX       = 3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/reset_debouncer.sv
// rtl/reset_debouncer.sv - button synchroniser and debouncer, one-cycle pulse per press
module reset_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_n,
    output logic press
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic            btn_s1;
    logic            btn_s2;
    logic [DB_W-1:0] low_cnt;

    // The counter parks at DEBOUNCE_CYCLES while held, so a long press fires once
    // and only a synced release re-arms it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            btn_s1  <= 1'b1;
            btn_s2  <= 1'b1;
            low_cnt <= '0;
            press   <= 1'b0;
        end else begin
            btn_s1 <= btn_n;
            btn_s2 <= btn_s1;
            press  <= 1'b0;
            if (btn_s2) begin
                low_cnt <= '0;
            end else if (low_cnt != DB_W'(DEBOUNCE_CYCLES)) begin
                low_cnt <= low_cnt + DB_W'(1);
                if (low_cnt == DB_W'(DEBOUNCE_CYCLES - 1))
                    press <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ddr4_reset_sequencer.sv
// rtl/ddr4_reset_sequencer.sv - EMIF calibration/retry sequencer gating SoC reset; option DDR4_SEQ_HEARTBEAT_EN
module ddr4_reset_sequencer
    import ddr4_seq_pkg::*;
#(
    parameter int CLK_HZ             = 50_000_000,
    parameter int DEBOUNCE_CYCLES    = 1_000_000,
    parameter int RESET_REQ_CYCLES   = 16,
    parameter int CAL_TIMEOUT_CYCLES = 50_000_000,
    parameter int MAX_RETRIES        = 3,
    parameter int SOC_HOLD_CYCLES    = 256
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_reset_n,
    input  logic       local_reset_done,
    input  logic       cal_success,
    input  logic       cal_fail,
    output logic       local_reset_req,
    output logic       soc_reset,
    output logic [3:0] led,
    output logic [2:0] seq_state,
    output logic [1:0] retry_cnt
);

    localparam int         CNT_MAX    = max3(RESET_REQ_CYCLES, CAL_TIMEOUT_CYCLES, SOC_HOLD_CYCLES);
    localparam int         CNT_W      = $clog2(CNT_MAX + 1);
    localparam logic [1:0] RETRY_LAST = 2'(MAX_RETRIES - 1);

    if (MAX_RETRIES < 1 || MAX_RETRIES > 3 || CLK_HZ < 2) begin : g_bad_params
        $error("ddr4_reset_sequencer: unsupported parameter set");
    end

    seq_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic             done_s1, done_s;
    logic             succ_s1, succ_s;
    logic             fail_s1, fail_s;
    logic             fail_prev;
    logic             fail_seen;
    logic             press;
    logic             aux_led;

    reset_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk    (clk),
        .reset_n(reset_n),
        .btn_n  (btn_reset_n),
        .press  (press)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            done_s1         <= 1'b0;
            done_s          <= 1'b0;
            succ_s1         <= 1'b0;
            succ_s          <= 1'b0;
            fail_s1         <= 1'b0;
            fail_s          <= 1'b0;
            fail_prev       <= 1'b0;
            state           <= ST_REQ;
            cnt             <= '0;
            local_reset_req <= 1'b0;
            soc_reset       <= 1'b1;
            retry_cnt       <= 2'd0;
            fail_seen       <= 1'b0;
        end else begin
            done_s1   <= local_reset_done;
            done_s    <= done_s1;
            succ_s1   <= cal_success;
            succ_s    <= succ_s1;
            fail_s1   <= cal_fail;
            fail_s    <= fail_s1;
            fail_prev <= fail_s;

            if (press) begin
                state           <= ST_REQ;
                cnt             <= '0;
                local_reset_req <= 1'b0;
                soc_reset       <= 1'b1;
                retry_cnt       <= 2'd0;
                fail_seen       <= 1'b0;
            end else begin
                case (state)
                    ST_REQ: begin
                        if (cnt == CNT_W'(RESET_REQ_CYCLES)) begin
                            local_reset_req <= 1'b0;
                            cnt             <= '0;
                            state           <= ST_WAITD;
                        end else begin
                            local_reset_req <= 1'b1;
                            cnt             <= cnt + CNT_W'(1);
                        end
                    end
                    ST_WAITD: begin
                        if (done_s) begin
                            cnt   <= '0;
                            state <= ST_WAITC;
                        end
                    end
                    ST_WAITC: begin
                        // Fail beats success; success on the terminal cycle still counts.
                        if (fail_s || (cnt == CNT_W'(CAL_TIMEOUT_CYCLES - 1) && !succ_s)) begin
                            fail_seen <= 1'b1;
                            retry_cnt <= retry_cnt + 2'd1;
                            cnt       <= '0;
                            state     <= (retry_cnt < RETRY_LAST) ? ST_REQ : ST_FAIL;
                        end else if (succ_s) begin
                            cnt   <= '0;
                            state <= ST_HOLD;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    ST_HOLD: begin
                        if (!succ_s) begin
                            fail_seen <= 1'b1;
                            cnt       <= '0;
                            state     <= ST_REQ;
                        end else if (cnt == CNT_W'(SOC_HOLD_CYCLES - 1)) begin
                            soc_reset <= 1'b0;
                            cnt       <= '0;
                            state     <= ST_RUN;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    ST_RUN: begin
                        if (!succ_s || (fail_s && !fail_prev)) begin
                            soc_reset <= 1'b1;
                            fail_seen <= 1'b1;
                            cnt       <= '0;
                            state     <= ST_REQ;
                        end
                    end
                    ST_FAIL: begin
                        local_reset_req <= 1'b0;
                        soc_reset       <= 1'b1;
                    end
                    default: begin
                        state <= ST_REQ;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

`ifdef DDR4_SEQ_HEARTBEAT_EN
    localparam int HB_HALF = CLK_HZ / 2;
    localparam int HB_W    = $clog2(HB_HALF + 1);

    logic [HB_W-1:0] hb_cnt;
    logic            hb;

    always_ff @(posedge clk) begin
        if (!reset_n || state != ST_RUN) begin
            hb_cnt <= '0;
            hb     <= 1'b0;
        end else if (hb_cnt == HB_W'(HB_HALF - 1)) begin
            hb_cnt <= '0;
            hb     <= ~hb;
        end else begin
            hb_cnt <= hb_cnt + HB_W'(1);
        end
    end

    assign aux_led = hb;
`else
    assign aux_led = (state == ST_FAIL);
`endif

    assign led[LED_CAL_OK]    = succ_s;
    assign led[LED_FAIL_SEEN] = fail_seen;
    assign led[LED_SOC_UP]    = ~soc_reset;
    assign led[LED_AUX]       = aux_led;
    assign seq_state          = state;

endmodule

// File: tb/tb_ddr4_reset_sequencer.sv
// tb/tb_ddr4_reset_sequencer.sv - directed bench for ddr4_reset_sequencer
module tb_ddr4_reset_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       btn_reset_n;
    logic       local_reset_done;
    logic       cal_success;
    logic       cal_fail;
    logic       local_reset_req;
    logic       soc_reset;
    logic [3:0] led;
    logic [2:0] seq_state;
    logic [1:0] retry_cnt;

    int n_vec = 0;
    int n_bad = 0;
    int req_rises = 0;
    logic req_prev = 1'b0;

    always #5 clk = ~clk;

    ddr4_reset_sequencer #(
        .CLK_HZ            (20),
        .DEBOUNCE_CYCLES   (4),
        .RESET_REQ_CYCLES  (4),
        .CAL_TIMEOUT_CYCLES(100),
        .MAX_RETRIES       (2),
        .SOC_HOLD_CYCLES   (8)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .btn_reset_n     (btn_reset_n),
        .local_reset_done(local_reset_done),
        .cal_success     (cal_success),
        .cal_fail        (cal_fail),
        .local_reset_req (local_reset_req),
        .soc_reset       (soc_reset),
        .led             (led),
        .seq_state       (seq_state),
        .retry_cnt       (retry_cnt)
    );

    always @(negedge clk) begin
        if (local_reset_req && !req_prev)
            req_rises = req_rises + 1;
        req_prev = local_reset_req;
    end

    task automatic expect_eq(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int hi;
        int soc_lo;
        int exp_aux_fail;
        int exp_aux_hb;
`ifdef DDR4_SEQ_HEARTBEAT_EN
        exp_aux_fail = 0;
        exp_aux_hb   = 1;
`else
        exp_aux_fail = 1;
        exp_aux_hb   = 0;
`endif
        reset_n          = 1'b0;
        btn_reset_n      = 1'b1;
        local_reset_done = 1'b0;
        cal_success      = 1'b0;
        cal_fail         = 1'b0;
        tick(3);
        expect_eq("rst_state", int'(seq_state), 0);
        expect_eq("rst_req", int'(local_reset_req), 0);
        expect_eq("rst_soc", int'(soc_reset), 1);
        expect_eq("rst_led", int'(led), 0);
        expect_eq("rst_retry", int'(retry_cnt), 0);

        // Power-up: request pulse width and hold-off before SoC release
        base = req_rises;
        reset_n = 1'b1;
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (local_reset_req) hi++;
        end
        expect_eq("req_width", hi, 4);
        expect_eq("req_pulses", req_rises - base, 1);
        expect_eq("waitd", int'(seq_state), 1);
        local_reset_done = 1'b1;
        tick(10);
        expect_eq("waitc", int'(seq_state), 2);
        cal_success = 1'b1;
        tick(10);
        expect_eq("soc_held", int'(soc_reset), 1);
        tick(1);
        expect_eq("soc_release", int'(soc_reset), 0);
        expect_eq("run_state", int'(seq_state), 4);
        expect_eq("run_led", int'(led), 5);
        tick(10);
        expect_eq("heartbeat", int'(led[3]), exp_aux_hb);

        // Loss of success in RUN
        cal_success = 1'b0;
        tick(3);
        expect_eq("drop_soc", int'(soc_reset), 1);
        expect_eq("drop_state", int'(seq_state), 0);
        expect_eq("drop_sticky", int'(led[1]), 1);

        // Success and fail together in WAITC: fail wins, then retry succeeds
        base = req_rises;
        tick(10);
        expect_eq("retry_waitc", int'(seq_state), 2);
        cal_success = 1'b1;
        cal_fail    = 1'b1;
        tick(3);
        expect_eq("both_state", int'(seq_state), 0);
        expect_eq("both_retry", int'(retry_cnt), 1);
        cal_fail = 1'b0;
        tick(30);
        expect_eq("retry_run", int'(seq_state), 4);
        expect_eq("retry_cnt_run", int'(retry_cnt), 1);
        expect_eq("two_pulses", req_rises - base, 2);
        expect_eq("retry_sticky", int'(led[1]), 1);

        // reset_n during request pulse
        cal_success = 1'b0;
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(2);
        expect_eq("req_cycle2", int'(local_reset_req), 1);
        reset_n = 1'b0;
        tick(1);
        expect_eq("abort_req", int'(local_reset_req), 0);
        expect_eq("abort_state", int'(seq_state), 0);
        expect_eq("abort_soc", int'(soc_reset), 1);
        expect_eq("abort_retry", int'(retry_cnt), 0);

        // Two timeouts -> FAIL
        reset_n = 1'b1;
        tick(250);
        expect_eq("fail_state", int'(seq_state), 5);
        expect_eq("fail_retry", int'(retry_cnt), 2);
        expect_eq("fail_soc", int'(soc_reset), 1);
        expect_eq("fail_sticky", int'(led[1]), 1);
        expect_eq("fail_aux", int'(led[3]), exp_aux_fail);
        hi = 0;
        soc_lo = 0;
        for (int i = 0; i < 1000; i++) begin
            tick(1);
            if (local_reset_req) hi++;
            if (!soc_reset) soc_lo++;
        end
        expect_eq("fail_req_quiet", hi, 0);
        expect_eq("fail_soc_held", soc_lo, 0);
        expect_eq("fail_terminal", int'(seq_state), 5);

        // Short press ignored, full press restarts once
        btn_reset_n = 1'b0;
        tick(3);
        btn_reset_n = 1'b1;
        tick(10);
        expect_eq("short_press", int'(seq_state), 5);
        base = req_rises;
        btn_reset_n = 1'b0;
        tick(6);
        btn_reset_n = 1'b1;
        tick(30);
        expect_eq("press_pulses", req_rises - base, 1);
        expect_eq("press_state", int'(seq_state), 2);
        expect_eq("press_retry", int'(retry_cnt), 0);
        expect_eq("press_sticky", int'(led[1]), 0);
        expect_eq("press_aux", int'(led[3]), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
